sp_ram_burst_reader: RTL

Read-side master for the 1024 x 72 single-port RAM block: accepts a (base, length) burst command, generates sequential RAM read addresses, absorbs the RAM's one-cycle registered-address read latency, and emits the words as a valid/ready stream with a last marker. It sits between the RAM and any downstream consumer that can stall, such as the accelerator datapath or a host readback path. It sustains one word per cycle under no backpressure and never drops or duplicates a word under arbitrary backpressure.

---
 rtl/sp_ram_pkg.sv | 20 ++
 rtl/sp_ram_fifo2.sv | 44 ++++
 rtl/sp_ram_burst_reader.sv | 118 +++++++++++
 3 files changed

// File: rtl/sp_ram_pkg.sv
// Shared constants and state encoding for the 1024 x 72 single-port RAM
// masters (burst reader now, burst writer later).
package sp_ram_pkg;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 72;
   localparam int LEN_W  = ADDR_W + 1;

   // Raw state codes, kept for code that compares against plain vectors
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      READ  = ST_READ,
      DRAIN = ST_DRAIN
   } state_t;

endpackage

// File: rtl/sp_ram_fifo2.sv
// Two-entry synchronous FIFO. The head entry is always visible on pop_data,
// so the consumer sees a word in the same cycle it becomes valid.
module sp_ram_fifo2 #(
   parameter int W = 73
) (
   input  logic         clka,
   input  logic         rsta,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic [1:0]   occ
);

   logic [W-1:0] mem_reg [2];
   logic         wr_ptr_reg;
   logic         rd_ptr_reg;
   logic [1:0]   occ_reg;

   // Storage, pointers and occupancy; reset clears contents so the output reads zero
   always_ff @(posedge clka) begin
      if (rsta) begin
         for (int i = 0; i < 2; i++) begin
            mem_reg[i] <= '0;
         end
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         occ_reg    <= 2'd0;
      end else begin
         if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
            wr_ptr_reg          <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
      end
   end

   assign pop_data = mem_reg[rd_ptr_reg];
   assign occ      = occ_reg;

endmodule

// File: rtl/sp_ram_burst_reader.sv
// Burst read master: turns a (base, length) command into sequential RAM reads,
// absorbs the one-cycle RAM read latency and presents the words as a
// valid/ready stream with a last marker. Issue is credit-limited so the
// two-entry output FIFO can never overflow under any backpressure.
module sp_ram_burst_reader
   import sp_ram_pkg::*;
(
   input  logic              clka,
   input  logic              rsta,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              done
);

   state_t            state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W-1:0] ram_addr_reg;
   logic [LEN_W-1:0]  remaining_reg;
   logic              inflight_reg;
   logic              inflight_last_reg;
   logic              done_reg;

   logic [1:0]        fifo_occ;
   logic [DATA_W:0]   fifo_dout;
   logic              pop;
   logic              issue;
   logic              cmd_fire;
   logic [2:0]        credit_used;

   assign m_valid = (fifo_occ != 2'd0);
   assign m_data  = fifo_dout[DATA_W-1:0];
   assign m_last  = m_valid & fifo_dout[DATA_W];
   assign pop     = m_valid & m_ready;

   // Words that will occupy the FIFO once this cycle's pop and the pending
   // capture settle; a new read may only start if that leaves a free slot.
   assign credit_used = {1'b0, fifo_occ} + {2'b00, inflight_reg} - {2'b00, pop};
   assign issue       = (state_reg == READ) && (credit_used < 3'd2);

   assign cmd_ready = (state_reg == IDLE) && !rsta;
   assign cmd_fire  = cmd_valid & cmd_ready;
   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;

   // The address goes to the RAM in the issue cycle itself; otherwise it holds
   assign ram_addr = issue ? addr_reg : ram_addr_reg;

   // Burst FSM, address/length counters and the one-deep read-in-flight tracker
   always_ff @(posedge clka) begin
      if (rsta) begin
         state_reg         <= IDLE;
         addr_reg          <= '0;
         ram_addr_reg      <= '0;
         remaining_reg     <= '0;
         inflight_reg      <= 1'b0;
         inflight_last_reg <= 1'b0;
         done_reg          <= 1'b0;
      end else begin
         done_reg          <= 1'b0;
         ram_addr_reg      <= ram_addr;
         inflight_reg      <= issue;
         inflight_last_reg <= issue && (remaining_reg == LEN_W'(1));
         case (state_reg)
            IDLE: begin
               if (cmd_fire) begin
                  if (cmd_len != '0) begin
                     addr_reg      <= cmd_base;
                     remaining_reg <= cmd_len;
                     state_reg     <= READ;
                  end else begin
                     // Empty burst completes immediately without touching the RAM
                     done_reg <= 1'b1;
                  end
               end
            end
            READ: begin
               if (issue) begin
                  addr_reg      <= addr_reg + ADDR_W'(1);
                  remaining_reg <= remaining_reg - LEN_W'(1);
                  if (remaining_reg == LEN_W'(1)) begin
                     state_reg <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && m_last) begin
                  state_reg <= IDLE;
                  done_reg  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Read data arrives one cycle after issue and is tagged with the last flag
   sp_ram_fifo2 #(
      .W(DATA_W + 1)
   ) u_fifo (
      .clka      (clka),
      .rsta      (rsta),
      .push      (inflight_reg),
      .push_data ({inflight_last_reg, ram_dout}),
      .pop       (pop),
      .pop_data  (fifo_dout),
      .occ       (fifo_occ)
   );

endmodule
